fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc_cur  in  32  current PC, from the PC register output
- pc_next  out  32  next PC, to the PC register input; the PC register loads it every cycle
- imem_req  out  1  instruction memory request, level
- imem_addr  out  32  instruction memory word address
- imem_ack  in  1  memory response; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- redirect  in  1  taken branch/jump from downstream
- redirect_pc  in  32  redirect target
- id_stall  in  1  decode cannot accept the IF/ID contents
- ifid_valid  out  1  IF/ID register holds a valid instruction
- ifid_pc  out  32  PC of the IF/ID instruction
- ifid_pc4  out  32  ifid_pc+4
- ifid_instr  out  32  IF/ID instruction

Function
REQ-002 The block SHALL implement a state machine with states REQ (request outstanding), HOLD (instruction parked in skid buffer) and DROP (stale request outstanding after redirect).
REQ-003 In REQ, the block SHALL drive imem_req=1 and imem_addr=pc_cur.
REQ-004 In DROP, the block SHALL drive imem_req=1 and imem_addr=drop_addr (registered address of the stale request).
REQ-005 In HOLD, the block SHALL drive imem_req=0.
REQ-006 When no redirect is asserted and imem_ack is not accepted, the block SHALL drive pc_next=pc_cur.
REQ-007 On imem_ack in REQ without redirect, the block SHALL drive pc_next=pc_cur+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-008 The IF/ID slot SHALL be free when ifid_valid=0 or id_stall=0; slot contents are consumed on any edge where ifid_valid=1 and id_stall=0.
REQ-009 On imem_ack in REQ without redirect and with the slot free, the block SHALL load {pc_cur, pc_cur+4, imem_rdata} into IF/ID, set ifid_valid=1 and stay in REQ.
REQ-010 On imem_ack in REQ without redirect and with the slot not free, the block SHALL load {pc_cur, imem_rdata} into the skid buffer and go to HOLD.
REQ-011 In HOLD, when the slot becomes free, the block SHALL move the skid buffer into IF/ID, set ifid_valid=1 and go to REQ.
REQ-012 When no new instruction enters IF/ID and the slot is consumed, the block SHALL clear ifid_valid to 0.
REQ-013 While ifid_valid=1 and id_stall=1, all ifid_* outputs SHALL hold.
REQ-014 Redirect SHALL have priority over every other event and SHALL act within the same cycle:
- pc_next={redirect_pc[31:2],2'b00} (misaligned targets are word-aligned)
- ifid_valid cleared at the next edge
- skid buffer discarded
REQ-015 On redirect in REQ without imem_ack, the block SHALL latch drop_addr=pc_cur and go to DROP.
REQ-016 On redirect in REQ with imem_ack, the block SHALL discard the returned data and stay in REQ.
REQ-017 On redirect in HOLD, the block SHALL go to REQ.
REQ-018 On redirect in DROP, the block SHALL update pc_next and stay in DROP.
REQ-019 In DROP, on imem_ack, the block SHALL discard the data and go to REQ; pc_next=pc_cur unless a redirect is asserted.
REQ-020 Latency: imem_ack in cycle N SHALL produce ifid_valid=1 in cycle N+1.
REQ-021 With zero-wait memory (imem_ack in the same cycle as imem_req) and no stall, throughput SHALL be one instruction per cycle.
REQ-022 At most two fetched instructions (IF/ID plus skid) SHALL be held; no instruction SHALL be lost or duplicated across stall or redirect.

Reset
REQ-023 While reset=1, the block SHALL set state=REQ, ifid_valid=0, ifid_pc=ifid_pc4=ifid_instr=0, skid buffer empty, drop_addr=0.
REQ-024 While reset=1, the block SHALL force imem_req=0 and pc_next=pc_cur.
REQ-025 Reset asserted mid-request SHALL abandon the outstanding request; any imem_ack arriving during reset SHALL be ignored.
REQ-026 After reset release with pc_cur=0, the first request SHALL be to address 0x00000000.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Reset release, zero-wait memory, no stall, 4 cycles -> ifid_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles; ifid_pc4=ifid_pc+4.
- Memory ack delayed by 3 cycles at pc 0x10 -> pc_next holds 0x10 for 3 cycles, then 0x14; ifid_valid rises the cycle after the ack.
- id_stall=1 for 3 cycles with zero-wait memory -> state HOLD, imem_req=0; after release, instructions 0x8 and 0xC appear in order, none lost.
- Redirect to 0x103 while a request to 0x20 is pending -> pc_next=0x100, state DROP, imem_addr stays 0x20; late data discarded; next ifid_pc=0x100.
- pc_cur=0xFFFFFFFC with ack -> pc_next=0x00000000, ifid_pc4=0x00000000.
- Reset pulse while in HOLD with ifid_valid=1 -> ifid_valid=0 immediately, skid empty, imem_req=0 until reset deasserts.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem, computes the next PC and fills the IF/ID register,
// parking one instruction in a skid buffer while decode is stalled.
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc_cur,
    output logic [31:0]  pc_next,
    fetch_unit_if.master imem,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         id_stall,
    output logic         ifid_valid,
    output logic [31:0]  ifid_pc,
    output logic [31:0]  ifid_pc4,
    output logic [31:0]  ifid_instr
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;

    logic            slot_free;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] skid_pc4;
    logic            imem_req_c;
    logic [XLEN-1:0] imem_addr_c;
    logic [XLEN-1:0] pc_next_c;

    assign slot_free = !ifid_valid_q || !id_stall;
    assign pc_inc    = pc_cur + XLEN'(4);
    assign skid_pc4  = skid_pc_q + XLEN'(4);

    // Next-state, IF/ID fill and memory/PC drive; redirect and reset override last.
    always_comb begin
        state_d      = state_q;
        drop_addr_d  = drop_addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_valid_d = ifid_valid_q && id_stall;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        imem_req_c   = 1'b0;
        imem_addr_c  = pc_cur;
        pc_next_c    = pc_cur;

        unique case (state_q)
            ST_REQ: begin
                imem_req_c  = 1'b1;
                imem_addr_c = pc_cur;
                if (redirect) begin
                    if (!imem.imem_ack) begin
                        drop_addr_d = pc_cur;
                        state_d     = ST_DROP;
                    end
                end else if (imem.imem_ack) begin
                    pc_next_c = pc_inc;
                    if (slot_free) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_cur;
                        ifid_pc4_d   = pc_inc;
                        ifid_instr_d = imem.imem_rdata;
                    end else begin
                        skid_pc_d    = pc_cur;
                        skid_instr_d = imem.imem_rdata;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = ST_REQ;
                end else if (slot_free) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_pc4_d   = skid_pc4;
                    ifid_instr_d = skid_instr_q;
                    state_d      = ST_REQ;
                end
            end
            ST_DROP: begin
                // Keep the stale request stable until memory answers it.
                imem_req_c  = 1'b1;
                imem_addr_c = drop_addr_q;
                if (imem.imem_ack && !redirect) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (redirect) begin
            pc_next_c    = {redirect_pc[XLEN-1:2], 2'b00};
            ifid_valid_d = 1'b0;
        end

        if (reset) begin
            imem_req_c = 1'b0;
            pc_next_c  = pc_cur;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_REQ;
            drop_addr_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            drop_addr_q  <= drop_addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign imem.imem_req  = imem_req_c;
    assign imem.imem_addr = imem_addr_c;
    assign pc_next        = pc_next_c;
    assign ifid_valid     = ifid_valid_q;
    assign ifid_pc        = ifid_pc_q;
    assign ifid_pc4       = ifid_pc4_q;
    assign ifid_instr     = ifid_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/latency/redirect traffic,
// with a program-order scoreboard of the instructions decode consumes.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .pc_next    (pc_next),
        .imem       (bus),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_stall   (id_stall),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int consumed = 0;

    // 0: zero-wait, 1: random latency, 2: ack driven by directed code
    int          mem_mode = 0;
    logic        man_ack  = 1'b0;
    int          wait_cnt = 0;
    logic        pc_force_en;
    logic [31:0] pc_force_val;

    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // PC register outside the block, loaded every cycle
    always @(posedge clk) pc_cur <= pc_force_en ? pc_force_val : pc_next;

    // Memory model reacting to the current-cycle request
    always @(posedge clk) begin
        #2;
        case (mem_mode)
            0: bus.imem_ack = bus.imem_req;
            1: begin
                if (bus.imem_req) begin
                    if (wait_cnt == 0) begin
                        bus.imem_ack = 1'b1;
                        wait_cnt     = $urandom_range(0, 3);
                    end else begin
                        bus.imem_ack = 1'b0;
                        wait_cnt     = wait_cnt - 1;
                    end
                end else begin
                    bus.imem_ack = 1'b0;
                end
            end
            default: bus.imem_ack = man_ack;
        endcase
        bus.imem_rdata = mem_word(bus.imem_addr);
    end

    // Monitor: decode must see the program in order, restarting at each (aligned) redirect target
    logic        hold_armed = 1'b0;
    logic [31:0] snap_pc, snap_pc4, snap_instr;
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
            chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
            chk("rst_pc_next", pc_next, pc_cur);
            hold_armed = 1'b0;
        end else begin
            if (hold_armed) begin
                chk("hold_valid", 32'(ifid_valid), 32'd1);
                chk("hold_pc", ifid_pc, snap_pc);
                chk("hold_pc4", ifid_pc4, snap_pc4);
                chk("hold_instr", ifid_instr, snap_instr);
            end
            hold_armed = ifid_valid && id_stall && !redirect;
            snap_pc    = ifid_pc;
            snap_pc4   = ifid_pc4;
            snap_instr = ifid_instr;
            if (ifid_valid && !id_stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: got pc %h expected no instruction", ifid_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("sb_pc", ifid_pc, e);
                    chk("sb_pc4", ifid_pc4, e + 32'd4);
                    chk("sb_instr", ifid_instr, mem_word(e));
                    exp_q.push_back(e + 32'd4);
                    consumed++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [31:0] tgt, input logic st);
        redirect    = r;
        redirect_pc = tgt;
        id_stall    = st;
        if (r) begin
            exp_q.delete();
            exp_q.push_back(tgt & 32'hFFFF_FFFC);
        end
    endtask

    task automatic reset_dut(input logic [31:0] start);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        pc_force_en  = 1'b1;
        pc_force_val = start;
        drive(1'b0, 32'd0, 1'b0);
        exp_q.delete();
        exp_q.push_back(start);
        tick();
        pc_force_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int last_c;
        int last_cons;
        reset        = 1'b1;
        pc_force_en  = 1'b1;
        pc_force_val = 32'd0;
        drive(1'b0, 32'd0, 1'b0);

        // Zero-wait streaming from reset
        mem_mode = 0;
        reset_dut(32'd0);
        #2;
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #2;
            chk("stream_valid", 32'(ifid_valid), 32'd1);
            chk("stream_pc", ifid_pc, 32'(4 * i));
            chk("stream_pc4", ifid_pc4, 32'(4 * i + 4));
        end

        // Ack delayed 3 cycles at 0x10
        mem_mode = 2;
        man_ack  = 1'b0;
        reset_dut(32'h10);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("wait_pc_next", pc_next, 32'h10);
            chk("wait_valid", 32'(ifid_valid), 32'd0);
            tick();
        end
        man_ack = 1'b1;
        #2;
        chk("ack_pc_next", pc_next, 32'h14);
        chk("ack_valid_early", 32'(ifid_valid), 32'd0);
        tick();
        man_ack = 1'b0;
        #2;
        chk("ack_valid_next", 32'(ifid_valid), 32'd1);
        chk("ack_ifid_pc", ifid_pc, 32'h10);

        // Decode stall for 3 cycles with zero-wait memory
        mem_mode = 0;
        reset_dut(32'd0);
        tick();
        tick();
        drive(1'b0, 32'd0, 1'b1);
        tick();
        #2;
        chk("stall_req", 32'(bus.imem_req), 32'd0);
        chk("stall_pc", ifid_pc, 32'h4);
        chk("stall_valid", 32'(ifid_valid), 32'd1);
        tick();
        #2;
        chk("stall_req2", 32'(bus.imem_req), 32'd0);
        chk("stall_pc_next", pc_next, 32'hC);
        tick();
        drive(1'b0, 32'd0, 1'b0);
        #2;
        chk("release_req", 32'(bus.imem_req), 32'd0);
        tick();
        #2;
        chk("release_pc8", ifid_pc, 32'h8);
        tick();
        #2;
        chk("release_pcC", ifid_pc, 32'hC);

        // Redirect while a request to 0x20 is outstanding
        mem_mode = 2;
        man_ack  = 1'b0;
        reset_dut(32'h20);
        drive(1'b1, 32'h103, 1'b0);
        #2;
        chk("redir_pc_next", pc_next, 32'h100);
        chk("redir_addr", bus.imem_addr, 32'h20);
        tick();
        drive(1'b0, 32'd0, 1'b0);
        #2;
        chk("drop_req", 32'(bus.imem_req), 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h20);
        chk("drop_pc_next", pc_next, 32'h100);
        tick();
        man_ack = 1'b1;
        #2;
        chk("drop_ack_addr", bus.imem_addr, 32'h20);
        chk("drop_ack_pc_next", pc_next, 32'h100);
        tick();
        man_ack  = 1'b0;
        mem_mode = 0;
        #2;
        chk("after_drop_addr", bus.imem_addr, 32'h100);
        chk("after_drop_valid", 32'(ifid_valid), 32'd0);
        chk("after_drop_pc_next", pc_next, 32'h104);
        tick();
        #2;
        chk("target_valid", 32'(ifid_valid), 32'd1);
        chk("target_pc", ifid_pc, 32'h100);

        // PC wrap at the top of the address space
        mem_mode = 0;
        reset_dut(32'hFFFF_FFFC);
        #2;
        chk("wrap_pc_next", pc_next, 32'h0);
        tick();
        #2;
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_pc4", ifid_pc4, 32'h0);

        // Reset pulse while an instruction sits in IF/ID and the skid buffer
        reset_dut(32'd0);
        tick();
        tick();
        drive(1'b0, 32'd0, 1'b1);
        tick();
        #2;
        chk("pre_rst_req", 32'(bus.imem_req), 32'd0);
        chk("pre_rst_valid", 32'(ifid_valid), 32'd1);
        mem_mode = 2;
        man_ack  = 1'b1;
        reset    = 1'b1;
        #1;
        chk("rst_now_valid", 32'(ifid_valid), 32'd0);
        chk("rst_now_req", 32'(bus.imem_req), 32'd0);
        chk("rst_now_pc_next", pc_next, 32'hC);
        tick();
        #2;
        chk("rst_ack_req", 32'(bus.imem_req), 32'd0);
        chk("rst_ack_valid", 32'(ifid_valid), 32'd0);
        chk("rst_ack_pc_next", pc_next, 32'hC);
        mem_mode = 0;
        man_ack  = 1'b0;
        reset_dut(32'd0);
        #2;
        chk("post_rst_valid", 32'(ifid_valid), 32'd0);
        tick();
        #2;
        chk("post_rst_pc0", ifid_pc, 32'h0);
        tick();
        #2;
        chk("post_rst_pc4", ifid_pc, 32'h4);

        // Random latency, stalls and redirects
        mem_mode = 1;
        reset_dut($urandom & 32'hFFFF_FFFC);
        last_c    = 0;
        last_cons = consumed;
        for (int c = 0; c < 3000; c++) begin
            tick();
            drive($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 3);
            if (consumed != last_cons) begin
                last_cons = consumed;
                last_c    = c;
            end else if (c - last_c > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL progress_timeout: got no instruction for %0d cycles, expected fewer than 200", c - last_c);
                break;
            end
        end
        drive(1'b0, 32'd0, 1'b0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
